// File: rtl/pfq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package pfq_pkg;

   localparam int unsigned PFQ_DEPTH = 16;
   localparam int unsigned PFQ_PTR_W = $clog2(PFQ_DEPTH);

   // Byte lanes of the decoder window
   localparam int unsigned LANE_OP  = 0;
   localparam int unsigned LANE_OP1 = 1;
   localparam int unsigned LANE_OP2 = 2;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StDrop
   } pfq_state_e;

   // Number of window bytes backed by the queue: min(count, 3)
   function automatic logic [1:0] pfq_win_cnt(input logic [4:0] count);
      return (count >= 5'd3) ? 2'd3 : count[1:0];
   endfunction

endpackage

// File: rtl/pfq_ram.sv
// Byte storage for the prefetch queue: one synchronous write port and three
// asynchronous read ports feeding the opcode/op1/op2 window lanes.
module pfq_ram #(
   parameter int unsigned Depth = 16,
   parameter int unsigned PtrW  = 4
) (
   input  logic            clk,
   input  logic            we,
   input  logic [PtrW-1:0] waddr,
   input  logic [7:0]      wdata,
   input  logic [PtrW-1:0] raddr0,
   input  logic [PtrW-1:0] raddr1,
   input  logic [PtrW-1:0] raddr2,
   output logic [7:0]      rdata0,
   output logic [7:0]      rdata1,
   output logic [7:0]      rdata2
);

   logic [7:0] mem [Depth];

   // Write the fetched byte at the queue tail
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Window lanes read straight from the array
   always_comb begin
      rdata0 = mem[raddr0];
      rdata1 = mem[raddr1];
      rdata2 = mem[raddr2];
   end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches bytes over a single-outstanding byte
// memory port into a circular queue and presents a 3-byte window plus its PC.
// Optional feature: define PFQ_BYPASS_EN to forward an acked byte into an empty
// window in the same cycle it arrives.
module prefetch_queue
   import pfq_pkg::*;
#(
   parameter int unsigned DEPTH = PFQ_DEPTH,
   parameter int unsigned AW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [7:0]    mem_rdata,
   input  logic          flush,
   input  logic [AW-1:0] flush_pc,
   output logic [23:0]   win_bytes,
   output logic [1:0]    win_cnt,
   output logic [AW-1:0] win_pc,
   input  logic          consume,
   input  logic [1:0]    consume_len,
   output logic [4:0]    q_count
);

   localparam int unsigned PtrW     = $clog2(DEPTH);
   localparam logic [4:0]  DepthCnt = 5'(DEPTH);

   pfq_state_e    state_q;
   logic          mem_req_q;
   logic [AW-1:0] mem_addr_q;
   logic [AW-1:0] fetch_pc_q, fetch_pc_nxt;

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]      count_q, count_d;
   logic [AW-1:0]   win_pc_q, win_pc_d;

   logic       ack_live;
   logic       push_ok;
   logic       bypass;
   logic       pop_ok;
   logic       take;
   logic       push;
   logic       pop;
   logic       space;
   logic [7:0] lane0, lane1, lane2;

   // Ack handling, consume validation and the optional same-cycle forward
   always_comb begin
      // Acks seen in StDrop belong to a request issued before the redirect
      ack_live = (state_q == StReq) && mem_ack;
      push_ok  = ack_live && !flush;
`ifdef PFQ_BYPASS_EN
      bypass   = push_ok && (count_q == 5'd0);
`else
      bypass   = 1'b0;
`endif
      win_cnt  = bypass ? 2'd1 : pfq_win_cnt(count_q);
      pop_ok   = consume && !flush && (consume_len != 2'd0) && (consume_len <= win_cnt);
      // A forwarded byte consumed in its arrival cycle never touches the queue
      take     = bypass && pop_ok;
      push     = push_ok && !take;
      pop      = pop_ok && !take;
      fetch_pc_nxt = flush ? flush_pc : (push_ok ? fetch_pc_q + AW'(1) : fetch_pc_q);
   end

   // Next-state for pointers, count and window PC; flush overrides everything
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      win_pc_d = win_pc_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         win_pc_d = flush_pc;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(consume_len);
         end
         if (pop_ok) begin
            win_pc_d = win_pc_q + AW'(consume_len);
         end
         count_d = count_q + {4'd0, push} - (pop ? {3'd0, consume_len} : 5'd0);
      end
      space = (count_d < DepthCnt);
   end

   // Queue bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         win_pc_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         win_pc_q <= win_pc_d;
      end
   end

   // Fetch FSM with registered request, address and fetch PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         fetch_pc_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_nxt;
         unique case (state_q)
            StIdle: begin
               if (!flush && space) begin
                  state_q    <= StReq;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= fetch_pc_q;
               end
            end
            StReq: begin
               if (flush) begin
                  // The bus has no abort, so an unanswered request is waited out
                  if (mem_ack) begin
                     mem_addr_q <= flush_pc;
                  end else begin
                     state_q <= StDrop;
                  end
               end else if (mem_ack) begin
                  if (space) begin
                     mem_addr_q <= fetch_pc_nxt;
                  end else begin
                     state_q   <= StIdle;
                     mem_req_q <= 1'b0;
                  end
               end
            end
            StDrop: begin
               if (mem_ack) begin
                  state_q    <= StReq;
                  mem_addr_q <= fetch_pc_nxt;
               end
            end
            default: begin
               state_q   <= StIdle;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   pfq_ram #(
      .Depth (DEPTH),
      .PtrW  (PtrW)
   ) u_ram (
      .clk    (clk),
      .we     (push),
      .waddr  (wr_ptr_q),
      .wdata  (mem_rdata),
      .raddr0 (rd_ptr_q + PtrW'(LANE_OP)),
      .raddr1 (rd_ptr_q + PtrW'(LANE_OP1)),
      .raddr2 (rd_ptr_q + PtrW'(LANE_OP2)),
      .rdata0 (lane0),
      .rdata1 (lane1),
      .rdata2 (lane2)
   );

   // Window assembly; lanes beyond win_cnt read as zero
   always_comb begin
      win_bytes = '0;
      if (win_cnt > 2'(LANE_OP)) begin
         win_bytes[8*LANE_OP +: 8] = bypass ? mem_rdata : lane0;
      end
      if (win_cnt > 2'(LANE_OP1)) begin
         win_bytes[8*LANE_OP1 +: 8] = lane1;
      end
      if (win_cnt > 2'(LANE_OP2)) begin
         win_bytes[8*LANE_OP2 +: 8] = lane2;
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign win_pc   = win_pc_q;
   assign q_count  = count_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: a byte memory that returns addr[7:0] and
// acks whenever ack_en is set, scenario tasks with hand-computed expectations.
module tb_prefetch_queue;

   logic        clk;
   logic        rst_n;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        flush;
   logic [15:0] flush_pc;
   logic [23:0] win_bytes;
   logic [1:0]  win_cnt;
   logic [15:0] win_pc;
   logic        consume;
   logic [1:0]  consume_len;
   logic [4:0]  q_count;
   logic        ack_en;

   int total = 0;
   int bad   = 0;

   prefetch_queue dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .win_bytes   (win_bytes),
      .win_cnt     (win_cnt),
      .win_pc      (win_pc),
      .consume     (consume),
      .consume_len (consume_len),
      .q_count     (q_count)
   );

   // Memory model: zero-wait responder
   assign mem_ack   = mem_req & ack_en;
   assign mem_rdata = mem_addr[7:0];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Flush to pc; ends two negedges later with a request at pc pending, queue empty
   task automatic restart(input logic [15:0] pc);
      flush = 1'b1; flush_pc = pc; ack_en = 1'b1; consume = 1'b0;
      @(negedge clk);
      flush = 1'b0; ack_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; flush_pc = '0; consume = 1'b0; consume_len = '0;
      ack_en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({mem_req, mem_addr, win_bytes, win_cnt, win_pc, q_count} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got req=%0b addr=%h win=%h cnt=%0d pc=%h q=%0d want all 0",
                  mem_req, mem_addr, win_bytes, win_cnt, win_pc, q_count);
      end
      ack_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
         bad++;
         $display("FAIL reset_first_req got req=%0b addr=%h want req=1 addr=0000",
                  mem_req, mem_addr);
      end
   endtask

   task automatic test_window();
      restart(16'h0400);
      #1;
      total++;
      if (win_cnt !== 2'd0 || mem_addr !== 16'h0400) begin
         bad++;
         $display("FAIL win_after_flush got cnt=%0d addr=%h want cnt=0 addr=0400",
                  win_cnt, mem_addr);
      end
      ack_en = 1'b1;
      repeat (3) @(negedge clk);
      ack_en = 1'b0;
      #1;
      total++;
      if (win_bytes !== 24'h020100 || win_cnt !== 2'd3 || win_pc !== 16'h0400) begin
         bad++;
         $display("FAIL win_three got win=%h cnt=%0d pc=%h want 020100 3 0400",
                  win_bytes, win_cnt, win_pc);
      end
      total++;
      if (q_count !== 5'd3 || mem_addr !== 16'h0403) begin
         bad++;
         $display("FAIL win_count got q=%0d addr=%h want 3 0403", q_count, mem_addr);
      end
   endtask

   task automatic test_fill();
      int acks = 0;
      int waited = 0;
      restart(16'h0400);
      ack_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (mem_ack) acks++;
         @(negedge clk);
      end
      #1;
      total++;
      if (acks != 16 || mem_req !== 1'b0 || q_count !== 5'd16) begin
         bad++;
         $display("FAIL fill_full got acks=%0d req=%0b q=%0d want 16 0 16", acks, mem_req, q_count);
      end
      total++;
      if (win_bytes !== 24'h020100 || win_pc !== 16'h0400) begin
         bad++;
         $display("FAIL fill_window got win=%h pc=%h want 020100 0400", win_bytes, win_pc);
      end
      ack_en = 1'b0; consume = 1'b1; consume_len = 2'd2;
      @(negedge clk);
      consume = 1'b0;
      #1;
      total++;
      if (q_count !== 5'd14 || win_pc !== 16'h0402 || win_bytes !== 24'h040302) begin
         bad++;
         $display("FAIL fill_consume got q=%0d pc=%h win=%h want 14 0402 040302",
                  q_count, win_pc, win_bytes);
      end
      while (mem_req !== 1'b1 && waited < 4) begin
         @(negedge clk);
         #1;
         waited++;
      end
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0410) begin
         bad++;
         $display("FAIL fill_rerequest got req=%0b addr=%h want 1 0410", mem_req, mem_addr);
      end
   endtask

   task automatic test_flush_pending();
      restart(16'h0400);
      ack_en = 1'b1;
      repeat (5) @(negedge clk);
      ack_en = 1'b0;
      #1;
      total++;
      if (mem_addr !== 16'h0405 || q_count !== 5'd5) begin
         bad++;
         $display("FAIL drop_setup got addr=%h q=%0d want 0405 5", mem_addr, q_count);
      end
      flush = 1'b1; flush_pc = 16'h8000;
      @(negedge clk);
      flush = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0405 || q_count !== 5'd0 || win_cnt !== 2'd0
          || win_pc !== 16'h8000) begin
         bad++;
         $display("FAIL drop_hold got req=%0b addr=%h q=%0d cnt=%0d pc=%h want 1 0405 0 0 8000",
                  mem_req, mem_addr, q_count, win_cnt, win_pc);
      end
      repeat (2) @(negedge clk);
      ack_en = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (mem_addr !== 16'h8000 || q_count !== 5'd0 || win_cnt !== 2'd0) begin
         bad++;
         $display("FAIL drop_stale got addr=%h q=%0d cnt=%0d want 8000 0 0",
                  mem_addr, q_count, win_cnt);
      end
      @(negedge clk);
      ack_en = 1'b0;
      #1;
      total++;
      if (win_cnt !== 2'd1 || win_bytes !== 24'h000000 || win_pc !== 16'h8000
          || q_count !== 5'd1) begin
         bad++;
         $display("FAIL drop_first_new got cnt=%0d win=%h pc=%h q=%0d want 1 000000 8000 1",
                  win_cnt, win_bytes, win_pc, q_count);
      end
   endtask

   task automatic test_addr_wrap();
      logic [15:0] exp_addr [3];
      exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000;
      restart(16'hFFFE);
      ack_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (mem_ack !== 1'b1 || mem_addr !== exp_addr[i]) begin
            bad++;
            $display("FAIL wrap_addr%0d got ack=%0b addr=%h want 1 %h",
                     i, mem_ack, mem_addr, exp_addr[i]);
         end
         @(negedge clk);
      end
      ack_en = 1'b0;
      #1;
      total++;
      if (win_bytes !== 24'h00FFFE || win_pc !== 16'hFFFE || q_count !== 5'd3) begin
         bad++;
         $display("FAIL wrap_window got win=%h pc=%h q=%0d want 00FFFE FFFE 3",
                  win_bytes, win_pc, q_count);
      end
      consume = 1'b1; consume_len = 2'd3;
      @(negedge clk);
      consume = 1'b0;
      #1;
      total++;
      if (win_pc !== 16'h0001 || q_count !== 5'd0 || mem_addr !== 16'h0001) begin
         bad++;
         $display("FAIL wrap_consume got pc=%h q=%0d addr=%h want 0001 0 0001",
                  win_pc, q_count, mem_addr);
      end
   endtask

   task automatic test_bad_consume();
      logic [1:0] lens [3];
      lens[0] = 2'd3; lens[1] = 2'd2; lens[2] = 2'd0;
      restart(16'h1234);
      ack_en = 1'b1;
      @(negedge clk);
      ack_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         consume = 1'b1; consume_len = lens[i];
         @(negedge clk);
         consume = 1'b0;
         #1;
         total++;
         if (q_count !== 5'd1 || win_pc !== 16'h1234 || win_bytes !== 24'h000034
             || win_cnt !== 2'd1) begin
            bad++;
            $display("FAIL ignore_len%0d got q=%0d pc=%h win=%h cnt=%0d want 1 1234 000034 1",
                     lens[i], q_count, win_pc, win_bytes, win_cnt);
         end
      end
      consume = 1'b1; consume_len = 2'd1;
      @(negedge clk);
      consume = 1'b0;
      #1;
      total++;
      if (q_count !== 5'd0 || win_pc !== 16'h1235 || win_cnt !== 2'd0) begin
         bad++;
         $display("FAIL accept_len1 got q=%0d pc=%h cnt=%0d want 0 1235 0", q_count, win_pc, win_cnt);
      end
   endtask

   task automatic test_stream();
      logic [7:0]  sb [$];
      logic [15:0] exp_fetch = 16'h2000;
      logic [15:0] exp_pc = 16'h2000;
      logic [23:0] exp_win;
      logic [1:0]  len = 2'd1;
      logic [1:0]  use_len;
      int          pushed = 0;
      int          cyc = 0;
      int          n;
      restart(16'h2000);
      while ((pushed < 40 || sb.size() > 0) && cyc < 300) begin
         ack_en = (pushed < 40);
         use_len = len;
         if (pushed >= 40 && sb.size() < int'(len)) use_len = 2'(sb.size());
         consume = (sb.size() >= int'(use_len)) && (use_len != 2'd0);
         consume_len = use_len;
         #1;
         n = (sb.size() > 3) ? 3 : sb.size();
         exp_win = '0;
         for (int i = 0; i < n; i++) exp_win[8*i +: 8] = sb[i];
         total++;
         if (win_bytes !== exp_win || win_cnt !== 2'(n) || win_pc !== exp_pc
             || q_count !== 5'(sb.size())) begin
            bad++;
            $display("FAIL stream_cyc%0d got win=%h cnt=%0d pc=%h q=%0d want %h %0d %h %0d",
                     cyc, win_bytes, win_cnt, win_pc, q_count, exp_win, n, exp_pc, sb.size());
         end
         if (pushed < 40) begin
            total++;
            if (mem_req !== 1'b1 || mem_addr !== exp_fetch) begin
               bad++;
               $display("FAIL stream_req%0d got req=%0b addr=%h want 1 %h",
                        cyc, mem_req, mem_addr, exp_fetch);
            end
         end
         if (consume) begin
            for (int i = 0; i < int'(use_len); i++) void'(sb.pop_front());
            exp_pc = exp_pc + 16'(use_len);
            len = (len == 2'd3) ? 2'd1 : len + 2'd1;
         end
         if (mem_ack) begin
            sb.push_back(exp_fetch[7:0]);
            exp_fetch = exp_fetch + 16'd1;
            pushed++;
         end
         @(negedge clk);
         cyc++;
      end
      consume = 1'b0; ack_en = 1'b0;
      #1;
      total++;
      if (pushed != 40 || sb.size() != 0 || q_count !== 5'd0 || win_pc !== 16'h2028) begin
         bad++;
         $display("FAIL stream_end got pushed=%0d left=%0d q=%0d pc=%h want 40 0 0 2028",
                  pushed, sb.size(), q_count, win_pc);
      end
   endtask

   initial begin
      test_reset();
      test_window();
      test_fill();
      test_flush_pending();
      test_addr_wrap();
      test_bad_consume();
      test_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
